// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: watches the running time against the stored alarm time,
// rings the buzzer with a square-wave beep, and handles stop, a limited number
// of snoozes per alarm event and an auto-off ring timeout.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a second tick on which CUR_TIME equals ALARM_TIME
// RING   | buzzer beeping; counting seconds towards auto-off
// SNOOZE | buzzer silent; counting seconds until the alarm rings again
module alarm_ring_ctrl #(
  parameter int unsigned BEEP_HALF      = 25000,
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [16:0] CUR_TIME,
  input  logic [16:0] ALARM_TIME,
  input  logic        ALARM_EN,
  input  logic        STOP_KEY,
  input  logic        SNOOZE_KEY,
  output logic        BUZZER,
  output logic        ALARM_ACTIVE,
  output logic        SNOOZE_ACTIVE,
  output logic [3:0]  SNOOZE_LEFT
);

  localparam int BW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_HALF - 1);
  localparam logic [6:0]    RING_LAST  = 7'(RING_SECONDS - 1);
  localparam logic [13:0]   SNZ_LOAD   = 14'(SNOOZE_MINUTES * 60);
  localparam logic [3:0]    SNZ_MAX    = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t        state;
  logic [5:0]    prev_sec;
  logic [BW-1:0] beep_cnt;
  logic [6:0]    ring_sec;
  logic [13:0]   snz_cnt;
  logic          tick;
  logic          time_match;

  // Seconds field delayed by one cycle; any change (normal count or a
  // time-set jump) yields a single-cycle tick.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) prev_sec <= 6'd0;
    else       prev_sec <= CUR_TIME[5:0];
  end

  assign tick       = (CUR_TIME[5:0] != prev_sec);
  assign time_match = (CUR_TIME == ALARM_TIME);

  // Alarm FSM with registered outputs and its beep/ring/snooze counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      BUZZER        <= 1'b0;
      ALARM_ACTIVE  <= 1'b0;
      SNOOZE_ACTIVE <= 1'b0;
      SNOOZE_LEFT   <= SNZ_MAX;
      beep_cnt      <= '0;
      ring_sec      <= 7'd0;
      snz_cnt       <= 14'd0;
    end else if (!ALARM_EN) begin
      state         <= IDLE;
      BUZZER        <= 1'b0;
      ALARM_ACTIVE  <= 1'b0;
      SNOOZE_ACTIVE <= 1'b0;
      SNOOZE_LEFT   <= SNZ_MAX;
      beep_cnt      <= '0;
      ring_sec      <= 7'd0;
      snz_cnt       <= 14'd0;
    end else begin
      case (state)
        IDLE: begin
          SNOOZE_LEFT <= SNZ_MAX;
          beep_cnt    <= '0;
          ring_sec    <= 7'd0;
          // A held match cannot retrigger: tick only fires on a seconds change.
          if (tick && time_match) begin
            state        <= RING;
            BUZZER       <= 1'b1;
            ALARM_ACTIVE <= 1'b1;
          end else begin
            BUZZER <= 1'b0;
          end
        end

        RING: begin
          if (STOP_KEY) begin
            state        <= IDLE;
            BUZZER       <= 1'b0;
            ALARM_ACTIVE <= 1'b0;
            SNOOZE_LEFT  <= SNZ_MAX;
            beep_cnt     <= '0;
            ring_sec     <= 7'd0;
          end else if (SNOOZE_KEY && (SNOOZE_LEFT != 4'd0)) begin
            state         <= SNOOZE;
            BUZZER        <= 1'b0;
            ALARM_ACTIVE  <= 1'b0;
            SNOOZE_ACTIVE <= 1'b1;
            SNOOZE_LEFT   <= SNOOZE_LEFT - 4'd1;
            snz_cnt       <= SNZ_LOAD;
            beep_cnt      <= '0;
            ring_sec      <= 7'd0;
          end else begin
            if (beep_cnt == BEEP_LAST) begin
              beep_cnt <= '0;
              BUZZER   <= ~BUZZER;
            end else begin
              beep_cnt <= beep_cnt + BW'(1);
            end
            if (tick) begin
              if (ring_sec == RING_LAST) begin
                // Auto-off; later assignments override the beep update above.
                state        <= IDLE;
                BUZZER       <= 1'b0;
                ALARM_ACTIVE <= 1'b0;
                SNOOZE_LEFT  <= SNZ_MAX;
                beep_cnt     <= '0;
                ring_sec     <= 7'd0;
              end else if (ring_sec != 7'h7f) begin
                ring_sec <= ring_sec + 7'd1;
              end
            end
          end
        end

        SNOOZE: begin
          BUZZER <= 1'b0;
          if (STOP_KEY) begin
            state         <= IDLE;
            SNOOZE_ACTIVE <= 1'b0;
            SNOOZE_LEFT   <= SNZ_MAX;
            snz_cnt       <= 14'd0;
          end else if (tick) begin
            if (snz_cnt == 14'd1) begin
              state         <= RING;
              BUZZER        <= 1'b1;
              ALARM_ACTIVE  <= 1'b1;
              SNOOZE_ACTIVE <= 1'b0;
              snz_cnt       <= 14'd0;
              beep_cnt      <= '0;
              ring_sec      <= 7'd0;
            end else if (snz_cnt != 14'd0) begin
              snz_cnt <= snz_cnt - 14'd1;
            end
          end
        end

        default: begin
          state         <= IDLE;
          BUZZER        <= 1'b0;
          ALARM_ACTIVE  <= 1'b0;
          SNOOZE_ACTIVE <= 1'b0;
          SNOOZE_LEFT   <= SNZ_MAX;
          beep_cnt      <= '0;
          ring_sec      <= 7'd0;
          snz_cnt       <= 14'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with a short beep, ring and snooze setup.
module tb_alarm_ring_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [16:0] CUR_TIME;
  logic [16:0] ALARM_TIME;
  logic        ALARM_EN;
  logic        STOP_KEY;
  logic        SNOOZE_KEY;
  logic        BUZZER;
  logic        ALARM_ACTIVE;
  logic        SNOOZE_ACTIVE;
  logic [3:0]  SNOOZE_LEFT;

  int checks   = 0;
  int failures = 0;

  alarm_ring_ctrl #(
    .BEEP_HALF      (4),
    .RING_SECONDS   (3),
    .SNOOZE_MINUTES (1),
    .MAX_SNOOZE     (2)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .CUR_TIME      (CUR_TIME),
    .ALARM_TIME    (ALARM_TIME),
    .ALARM_EN      (ALARM_EN),
    .STOP_KEY      (STOP_KEY),
    .SNOOZE_KEY    (SNOOZE_KEY),
    .BUZZER        (BUZZER),
    .ALARM_ACTIVE  (ALARM_ACTIVE),
    .SNOOZE_ACTIVE (SNOOZE_ACTIVE),
    .SNOOZE_LEFT   (SNOOZE_LEFT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  // Advance seconds on a time that never matches the alarm (08:00:xx).
  task automatic tick_other();
    int s;
    s = (int'(CUR_TIME[5:0]) + 1) % 60;
    CUR_TIME = {5'd8, 6'd0, 6'(s)};
    @(negedge CLK);
  endtask

  // 07:29:59 -> 07:30:00; RING is entered on the edge just before return.
  task automatic enter_ring();
    CUR_TIME = hms(7, 29, 59);
    @(negedge CLK);
    CUR_TIME = hms(7, 30, 0);
    @(negedge CLK);
  endtask

  task automatic pulse_stop();
    STOP_KEY = 1'b1;
    @(negedge CLK);
    STOP_KEY = 1'b0;
  endtask

  task automatic pulse_snooze();
    SNOOZE_KEY = 1'b1;
    @(negedge CLK);
    SNOOZE_KEY = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++; if (BUZZER !== 1'b0) begin failures++; $display("FAIL reset_buzzer got=%0b exp=0", BUZZER); end
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL reset_alarm_active got=%0b exp=0", ALARM_ACTIVE); end
    checks++; if (SNOOZE_ACTIVE !== 1'b0) begin failures++; $display("FAIL reset_snooze_active got=%0b exp=0", SNOOZE_ACTIVE); end
    checks++; if (SNOOZE_LEFT !== 4'd2) begin failures++; $display("FAIL reset_snooze_left got=%0d exp=2", SNOOZE_LEFT); end
    RESET = 1'b0;
    @(negedge CLK);
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%0b exp=0", ALARM_ACTIVE); end
  endtask

  task automatic test_match();
    logic exp_b;
    ALARM_EN = 1'b1;
    CUR_TIME = hms(7, 29, 59);
    @(negedge CLK);
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL match_early got=%0b exp=0", ALARM_ACTIVE); end
    CUR_TIME = hms(7, 30, 0);
    @(negedge CLK);
    checks++; if (ALARM_ACTIVE !== 1'b1) begin failures++; $display("FAIL match_active got=%0b exp=1", ALARM_ACTIVE); end
    checks++; if (BUZZER !== 1'b1) begin failures++; $display("FAIL match_buzzer got=%0b exp=1", BUZZER); end
    // Buzzer is high for 4 cycles, low for 4, high again.
    for (int i = 1; i < 12; i++) begin
      @(negedge CLK);
      exp_b = ((i / 4) % 2) == 0;
      checks++; if (BUZZER !== exp_b) begin failures++; $display("FAIL beep_pattern cycle=%0d got=%0b exp=%0b", i, BUZZER, exp_b); end
    end
    pulse_stop();
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL stop_active got=%0b exp=0", ALARM_ACTIVE); end
    checks++; if (BUZZER !== 1'b0) begin failures++; $display("FAIL stop_buzzer got=%0b exp=0", BUZZER); end
  endtask

  task automatic test_auto_off();
    enter_ring();
    tick_other();
    checks++; if (ALARM_ACTIVE !== 1'b1) begin failures++; $display("FAIL auto_off_tick1 got=%0b exp=1", ALARM_ACTIVE); end
    tick_other();
    checks++; if (ALARM_ACTIVE !== 1'b1) begin failures++; $display("FAIL auto_off_tick2 got=%0b exp=1", ALARM_ACTIVE); end
    tick_other();
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL auto_off_tick3 got=%0b exp=0", ALARM_ACTIVE); end
    checks++; if (BUZZER !== 1'b0) begin failures++; $display("FAIL auto_off_buzzer got=%0b exp=0", BUZZER); end
    checks++; if (SNOOZE_LEFT !== 4'd2) begin failures++; $display("FAIL auto_off_left got=%0d exp=2", SNOOZE_LEFT); end
  endtask

  task automatic test_snooze();
    enter_ring();
    pulse_snooze();
    checks++; if (SNOOZE_ACTIVE !== 1'b1) begin failures++; $display("FAIL snz1_active got=%0b exp=1", SNOOZE_ACTIVE); end
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL snz1_alarm got=%0b exp=0", ALARM_ACTIVE); end
    checks++; if (SNOOZE_LEFT !== 4'd1) begin failures++; $display("FAIL snz1_left got=%0d exp=1", SNOOZE_LEFT); end
    checks++; if (BUZZER !== 1'b0) begin failures++; $display("FAIL snz1_buzzer got=%0b exp=0", BUZZER); end
    repeat (58) tick_other();
    checks++; if (SNOOZE_ACTIVE !== 1'b1) begin failures++; $display("FAIL snz1_t58 got=%0b exp=1", SNOOZE_ACTIVE); end
    // 59th tick lands on the alarm time; the match must be ignored.
    CUR_TIME = hms(7, 30, 0);
    @(negedge CLK);
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL snz_match_ignored got=%0b exp=0", ALARM_ACTIVE); end
    checks++; if (SNOOZE_ACTIVE !== 1'b1) begin failures++; $display("FAIL snz1_t59 got=%0b exp=1", SNOOZE_ACTIVE); end
    tick_other();
    checks++; if (ALARM_ACTIVE !== 1'b1) begin failures++; $display("FAIL snz1_rering got=%0b exp=1", ALARM_ACTIVE); end
    checks++; if (BUZZER !== 1'b1) begin failures++; $display("FAIL snz1_rering_buzzer got=%0b exp=1", BUZZER); end
    checks++; if (SNOOZE_ACTIVE !== 1'b0) begin failures++; $display("FAIL snz1_rering_snz got=%0b exp=0", SNOOZE_ACTIVE); end

    pulse_snooze();
    checks++; if (SNOOZE_LEFT !== 4'd0) begin failures++; $display("FAIL snz2_left got=%0d exp=0", SNOOZE_LEFT); end
    checks++; if (SNOOZE_ACTIVE !== 1'b1) begin failures++; $display("FAIL snz2_active got=%0b exp=1", SNOOZE_ACTIVE); end
    repeat (59) tick_other();
    checks++; if (SNOOZE_ACTIVE !== 1'b1) begin failures++; $display("FAIL snz2_t59 got=%0b exp=1", SNOOZE_ACTIVE); end
    tick_other();
    checks++; if (ALARM_ACTIVE !== 1'b1) begin failures++; $display("FAIL snz2_rering got=%0b exp=1", ALARM_ACTIVE); end

    pulse_snooze();
    checks++; if (ALARM_ACTIVE !== 1'b1) begin failures++; $display("FAIL snz3_stay_ring got=%0b exp=1", ALARM_ACTIVE); end
    checks++; if (SNOOZE_ACTIVE !== 1'b0) begin failures++; $display("FAIL snz3_no_snooze got=%0b exp=0", SNOOZE_ACTIVE); end
    checks++; if (SNOOZE_LEFT !== 4'd0) begin failures++; $display("FAIL snz3_left got=%0d exp=0", SNOOZE_LEFT); end
    pulse_stop();
    checks++; if (SNOOZE_LEFT !== 4'd2) begin failures++; $display("FAIL stop_restore_left got=%0d exp=2", SNOOZE_LEFT); end
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL stop_after_snz got=%0b exp=0", ALARM_ACTIVE); end
  endtask

  task automatic test_priority();
    enter_ring();
    STOP_KEY   = 1'b1;
    SNOOZE_KEY = 1'b1;
    @(negedge CLK);
    STOP_KEY   = 1'b0;
    SNOOZE_KEY = 1'b0;
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL prio_stop_alarm got=%0b exp=0", ALARM_ACTIVE); end
    checks++; if (SNOOZE_ACTIVE !== 1'b0) begin failures++; $display("FAIL prio_stop_snooze got=%0b exp=0", SNOOZE_ACTIVE); end
    checks++; if (SNOOZE_LEFT !== 4'd2) begin failures++; $display("FAIL prio_stop_left got=%0d exp=2", SNOOZE_LEFT); end

    enter_ring();
    pulse_snooze();
    checks++; if (SNOOZE_ACTIVE !== 1'b1) begin failures++; $display("FAIL prio_pre_snooze got=%0b exp=1", SNOOZE_ACTIVE); end
    ALARM_EN = 1'b0;
    @(negedge CLK);
    checks++; if (SNOOZE_ACTIVE !== 1'b0) begin failures++; $display("FAIL prio_en_snooze got=%0b exp=0", SNOOZE_ACTIVE); end
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL prio_en_alarm got=%0b exp=0", ALARM_ACTIVE); end
    checks++; if (BUZZER !== 1'b0) begin failures++; $display("FAIL prio_en_buzzer got=%0b exp=0", BUZZER); end
    @(negedge CLK);
    checks++; if (SNOOZE_LEFT !== 4'd2) begin failures++; $display("FAIL prio_en_left got=%0d exp=2", SNOOZE_LEFT); end
    ALARM_EN = 1'b1;
  endtask

  task automatic test_no_retrigger();
    enter_ring();
    pulse_stop();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL no_retrigger cycle=%0d got=%0b exp=0", i, ALARM_ACTIVE); end
    end
    tick_other();
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL nonmatch_tick got=%0b exp=0", ALARM_ACTIVE); end
    CUR_TIME = hms(7, 30, 0);
    @(negedge CLK);
    checks++; if (ALARM_ACTIVE !== 1'b1) begin failures++; $display("FAIL rering_on_match got=%0b exp=1", ALARM_ACTIVE); end
  endtask

  task automatic test_async_reset();
    enter_ring();
    @(negedge CLK);
    checks++; if (BUZZER !== 1'b1) begin failures++; $display("FAIL pre_reset_buzzer got=%0b exp=1", BUZZER); end
    #2 RESET = 1'b1;
    #1;
    checks++; if (BUZZER !== 1'b0) begin failures++; $display("FAIL async_buzzer got=%0b exp=0", BUZZER); end
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL async_alarm got=%0b exp=0", ALARM_ACTIVE); end
    checks++; if (SNOOZE_ACTIVE !== 1'b0) begin failures++; $display("FAIL async_snooze got=%0b exp=0", SNOOZE_ACTIVE); end
    checks++; if (SNOOZE_LEFT !== 4'd2) begin failures++; $display("FAIL async_left got=%0d exp=2", SNOOZE_LEFT); end
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checks++; if (BUZZER !== 1'b0) begin failures++; $display("FAIL release_buzzer got=%0b exp=0", BUZZER); end
    checks++; if (ALARM_ACTIVE !== 1'b0) begin failures++; $display("FAIL release_alarm got=%0b exp=0", ALARM_ACTIVE); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET      = 1'b1;
    ALARM_EN   = 1'b0;
    STOP_KEY   = 1'b0;
    SNOOZE_KEY = 1'b0;
    CUR_TIME   = 17'd0;
    ALARM_TIME = hms(7, 30, 0);
    @(negedge CLK);
    test_reset();
    test_match();
    test_auto_off();
    test_snooze();
    test_priority();
    test_no_retrigger();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
